// File: rtl/sockit_spi_ser.sv
// sockit_spi_ser: bus-slave SPI serializer behind the SPI FIFO.
// Build option: SOCKIT_SPI_SER_MODE_EN adds CPOL/CPHA in CTRL[25:24].
//
// Ports:
//   clk, rst             clock, async active-high reset
//   bsi_wen/ren/adr/wdt  bus request (adr 0 DATA, adr 1 CTRL)
//   bsi_rdt              read data, combinational from registers
//   bsi_wrq              wait request while a transfer runs
//   spi_sclk/ss_n/mosi   SPI outputs; spi_miso SPI input
module sockit_spi_ser #(
  parameter int BAW = 2,
  parameter int CDW = 8,
  parameter int SSW = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bsi_wen,
  input  logic           bsi_ren,
  input  logic [BAW-1:0] bsi_adr,
  input  logic [31:0]    bsi_wdt,
  output logic [31:0]    bsi_rdt,
  output logic           bsi_wrq,
  output logic           spi_sclk,
  output logic [SSW-1:0] spi_ss_n,
  output logic           spi_mosi,
  input  logic           spi_miso
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD
  } state_t;

  state_t state_q, state_d;

  logic [CDW-1:0] div_q, dcnt_q;
  logic [4:0]     len_q, cnt_q;
  logic           hold_q;
  logic [SSW-1:0] sel_q;
  logic [31:0]    tx_q, rx_q;
  logic           mosi_q, last_q;
  logic           cpol, cpha;
  logic           busy, tick, adr0, adr1;
  logic           start, ctrl_we;
  logic           ent_hi, ent_lo;
  logic [31:0]    ctrl_rd;
  logic           unused_wdt;

  assign busy    = (state_q != IDLE);
  assign tick    = busy & (dcnt_q == div_q);
  assign adr0    = (bsi_adr == '0);
  assign adr1    = (bsi_adr == BAW'(1));
  assign bsi_wrq = busy & (bsi_wen | bsi_ren)
                 & (adr0 | (adr1 & bsi_wen));
  assign start   = bsi_wen & adr0 & ~busy;
  assign ctrl_we = bsi_wen & adr1 & ~busy;

  // the last bit is flagged on the falling edge, so SHIFT_LO
  // only returns to SHIFT_HI while bits remain
  assign ent_hi = tick & ((state_q == SETUP)
                | ((state_q == SHIFT_LO) & ~last_q));
  assign ent_lo = tick & (state_q == SHIFT_HI);

  assign unused_wdt = ^bsi_wdt;

`ifdef SOCKIT_SPI_SER_MODE_EN
  logic cpol_q, cpha_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else if (ctrl_we) begin
      cpol_q <= bsi_wdt[24];
      cpha_q <= bsi_wdt[25];
    end
  end

  assign cpol = cpol_q;
  assign cpha = cpha_q;
`else
  assign cpol = 1'b0;
  assign cpha = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = SETUP;
      SETUP:    if (tick)  state_d = SHIFT_HI;
      SHIFT_HI: if (tick)  state_d = SHIFT_LO;
      SHIFT_LO: if (tick)  state_d = last_q ? HOLD : SHIFT_HI;
      HOLD:     if (tick)  state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_q <= '0;
      div_q  <= '0;
      len_q  <= 5'd31;
      hold_q <= 1'b0;
      sel_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      cnt_q  <= '0;
      mosi_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      if (!busy || tick) dcnt_q <= '0;
      else               dcnt_q <= dcnt_q + CDW'(1);

      if (ctrl_we) begin
        div_q  <= bsi_wdt[CDW-1:0];
        len_q  <= bsi_wdt[12:8];
        hold_q <= bsi_wdt[15];
        sel_q  <= bsi_wdt[16 +: SSW];
      end

      if (start) begin
        tx_q   <= bsi_wdt;
        cnt_q  <= len_q;
        rx_q   <= '0;
        last_q <= 1'b0;
        if (!cpha) mosi_q <= bsi_wdt[len_q];
      end

      if (ent_hi) begin
        if (!cpha) begin
          rx_q <= {rx_q[30:0], spi_miso};
        end else if (state_q == SETUP) begin
          mosi_q <= tx_q[cnt_q];
        end else begin
          cnt_q  <= cnt_q - 5'd1;
          mosi_q <= tx_q[cnt_q - 5'd1];
        end
      end

      if (ent_lo) begin
        last_q <= (cnt_q == 5'd0);
        if (cpha) begin
          rx_q <= {rx_q[30:0], spi_miso};
        end else if (cnt_q != 5'd0) begin
          cnt_q  <= cnt_q - 5'd1;
          mosi_q <= tx_q[cnt_q - 5'd1];
        end
      end
    end
  end

  assign spi_sclk = cpol ^ (state_q == SHIFT_HI);
  assign spi_mosi = mosi_q;
  assign spi_ss_n = ~(sel_q & {SSW{busy | hold_q}});

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[CDW-1:0]     = div_q;
    ctrl_rd[12:8]        = len_q;
    ctrl_rd[15]          = hold_q;
    ctrl_rd[16 +: SSW]   = sel_q;
    ctrl_rd[24]          = cpol;
    ctrl_rd[25]          = cpha;
    ctrl_rd[31]          = busy;
  end

  always_comb begin
    bsi_rdt = '0;
    if (bsi_ren) begin
      unique case (1'b1)
        adr0:    bsi_rdt = rx_q;
        adr1:    bsi_rdt = ctrl_rd;
        default: bsi_rdt = '0;
      endcase
    end
  end

endmodule
